// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo read-side stream adapter.
// The output buffer is 3 entries deep, so its pointers wrap modulo 3 rather than modulo 4.
package fifo_pkg;

   localparam int STREAM_BUF_DEPTH = 3;
   localparam int STREAM_PTR_W     = 2;

   typedef logic [STREAM_PTR_W-1:0] stream_ptr_t;
   typedef logic [STREAM_PTR_W-1:0] stream_level_t;

   // Advance a buffer pointer: 0 -> 1 -> 2 -> 0.
   function automatic stream_ptr_t ptr_inc(input stream_ptr_t ptr);
      if (ptr == stream_ptr_t'(STREAM_BUF_DEPTH - 1)) begin
         return '0;
      end
      return ptr + stream_ptr_t'(1);
   endfunction

endpackage : fifo_pkg

// File: rtl/fifo_stream_buf.sv
// 3-entry circular output buffer. Head data and valid come straight from registers.
// A pop is honoured only while the buffer holds a word.
module fifo_stream_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] head_data_o,
   output logic                  head_valid_o,
   output stream_level_t         level_o
);

   logic [DATA_WIDTH-1:0] mem_q [STREAM_BUF_DEPTH];

   stream_ptr_t   rd_ptr_q, rd_ptr_d;
   stream_ptr_t   wr_ptr_q, wr_ptr_d;
   stream_level_t count_q,  count_d;
   logic          pop_ok;

   always_comb begin
      // NOTE: every signal gets a default first, so no path through this block can infer a latch.
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      pop_ok   = pop_i && (count_q != '0);

      if (push_i) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      unique case ({push_i, pop_ok})
         2'b10:   count_d = count_q + stream_level_t'(1);
         2'b01:   count_d = count_q - stream_level_t'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: data storage is deliberately not reset; count_q gates its visibility through head_valid_o.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_data_o  = mem_q[rd_ptr_q];
   assign head_valid_o = (count_q != '0);
   assign level_o      = count_q;

   a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= stream_level_t'(STREAM_BUF_DEPTH));

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && !pop_ok && (count_q == stream_level_t'(STREAM_BUF_DEPTH))));

   a_rd_ptr_range : assert property (@(posedge clk) disable iff (!rst_n)
      rd_ptr_q < stream_ptr_t'(STREAM_BUF_DEPTH));

   a_wr_ptr_range : assert property (@(posedge clk) disable iff (!rst_n)
      wr_ptr_q < stream_ptr_t'(STREAM_BUF_DEPTH));

endmodule : fifo_stream_buf

// File: rtl/fifo_stream_out.sv
// Read-side adapter for the single-clock fifo. It issues reads only when the output buffer has
// room for the word already in flight plus a new one, which lets it absorb the 1-cycle read latency.
module fifo_stream_out
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  fifo_rd_en_o,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
   input  logic                  fifo_empty_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [1:0]            level_o
);

   if (DATA_WIDTH <= 0) begin : g_bad_width
      $error("fifo_stream_out: DATA_WIDTH must be > 0");
   end

   logic                inflight_q, inflight_d;
   stream_level_t       level;
   logic [STREAM_PTR_W:0] fill;
   logic                rd_en;
   logic                pop;

   // Committed slots = buffered words plus the word the fifo is returning this cycle.
   // rst_n is included so the strobe drops immediately on an asynchronous reset.
   always_comb begin
      fill       = {1'b0, level} + {{STREAM_PTR_W{1'b0}}, inflight_q};
      rd_en      = rst_n && !fifo_empty_i && (fill < (STREAM_PTR_W+1)'(STREAM_BUF_DEPTH));
      inflight_d = rd_en;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

   assign pop = m_valid_o && m_ready_i;

   fifo_stream_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (inflight_q),
      .push_data_i  (fifo_rd_data_i),
      .pop_i        (pop),
      .head_data_o  (m_data_o),
      .head_valid_o (m_valid_o),
      .level_o      (level)
   );

   assign fifo_rd_en_o = rd_en;
   assign level_o      = level;

   a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(fifo_rd_en_o && fifo_empty_i));

endmodule : fifo_stream_out

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: behavioural fifo with 1-cycle read latency, scoreboard queue filled on
// every fifo write, and a monitor that compares stream output against the queue head.
module tb_fifo_stream_out;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [1:0]    level;

   logic [DW-1:0] mem[$];
   logic [DW-1:0] exp_q[$];

   int n_compared   = 0;
   int n_mismatched = 0;

   fifo_stream_out #(.DATA_WIDTH(DW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fifo_rd_en_o   (fifo_rd_en),
      .fifo_rd_data_i (fifo_rd_data),
      .fifo_empty_i   (fifo_empty),
      .m_data_o       (m_data),
      .m_valid_o      (m_valid),
      .m_ready_i      (m_ready),
      .level_o        (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      mem.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Fifo model: read strobe sampled at the edge, data and empty flag updated shortly after.
   initial begin : fifo_model
      logic take;
      forever begin
         @(posedge clk);
         take = fifo_rd_en && rst_n;
         #2;
         if (take) begin
            if (mem.size() == 0) begin
               check("fifo_underflow", 1'b1, 1'b0);
            end else begin
               fifo_rd_data = mem.pop_front();
            end
         end
         fifo_empty = (mem.size() == 0);
      end
   end

   // Monitor: compares stream output with the scoreboard head every cycle.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (fifo_rd_en) check("rd_en_while_empty", fifo_empty, 1'b0);
            check("valid_vs_level", m_valid, level != 2'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_valid", m_valid, 1'b0);
            end else if (m_valid) begin
               check("stream_data", m_data, exp_q[0]);
               if (m_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic exp_rd [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic exp_v  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [DW-1:0] exp_d [6] = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
      int pulses;
      int waited;
      int bubbles;
      bit found;

      // Reset values
      rst_n = 1'b0;
      m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", m_valid, 1'b0);
      check("reset_level", level, 2'd0);
      check("reset_rd_en", fifo_rd_en, 1'b0);
      rst_n = 1'b1;
      step();

      // Test 1: three preloaded words, consumer always ready
      m_ready = 1'b1;
      push_word(32'h11);
      push_word(32'h22);
      push_word(32'h33);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("t1_rd_en_c%0d", c), fifo_rd_en, exp_rd[c]);
         check($sformatf("t1_valid_c%0d", c), m_valid, exp_v[c]);
         if (exp_v[c]) check($sformatf("t1_data_c%0d", c), m_data, exp_d[c]);
         step();
      end
      @(negedge clk);
      check("t1_level_end", level, 2'd0);
      step();

      // Test 2: backpressure caps fifo reads at three
      m_ready = 1'b0;
      for (int i = 0; i < 10; i++) push_word(32'h100 + i);
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (fifo_rd_en) pulses++;
         step();
      end
      check("t2_rd_pulses", pulses, 3);
      @(negedge clk);
      check("t2_level_full", level, 2'd3);
      check("t2_rd_en_held", fifo_rd_en, 1'b0);
      step();
      m_ready = 1'b1;
      bubbles = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (!m_valid) bubbles++;
         step();
      end
      check("t2_bubbles", bubbles, 0);
      @(negedge clk);
      check("t2_valid_end", m_valid, 1'b0);
      check("t2_level_end", level, 2'd0);
      step();

      // Test 3: 100-word stream, 2-cycle latency, no bubbles
      for (int i = 0; i < 100; i++) push_word(i);
      waited = 0;
      found = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (m_valid) begin
            found = 1'b1;
            break;
         end
         waited++;
         step();
      end
      check("t3_first_valid_seen", found, 1'b1);
      check("t3_latency", waited, 2);
      bubbles = 0;
      for (int k = 0; k < 100; k++) begin
         if (!m_valid) bubbles++;
         step();
         @(negedge clk);
      end
      check("t3_bubbles", bubbles, 0);
      check("t3_valid_end", m_valid, 1'b0);
      step();

      // Test 4: random ready and random fifo writes
      for (int c = 0; c < 400; c++) begin
         m_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) push_word($urandom);
         step();
      end
      m_ready = 1'b1;
      for (int c = 0; c < 500; c++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      repeat (3) step();
      check("t4_drained", exp_q.size(), 0);
      check("t4_level_end", level, 2'd0);

      // Test 5: asynchronous reset with two words buffered and one in flight
      m_ready = 1'b0;
      for (int i = 0; i < 10; i++) push_word(32'h300 + i);
      found = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (level == 2'd2) begin
            found = 1'b1;
            break;
         end
         step();
      end
      check("t5_level_two_seen", found, 1'b1);
      check("t5_valid_before", m_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      mem.delete();
      exp_q.delete();
      #1;
      check("t5_valid_in_reset", m_valid, 1'b0);
      check("t5_level_in_reset", level, 2'd0);
      check("t5_rd_en_in_reset", fifo_rd_en, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      m_ready = 1'b1;
      push_word(32'hA5);
      found = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (m_valid) begin
            found = 1'b1;
            break;
         end
         step();
      end
      check("t5_word_after_reset_seen", found, 1'b1);
      check("t5_first_data", m_data, 32'hA5);
      repeat (3) step();
      check("t5_level_end", level, 2'd0);

      // Test 6: ready toggling 1,0 across seven words exercises the pointer wrap
      m_ready = 1'b0;
      for (int i = 0; i < 7; i++) push_word(32'h200 + i);
      for (int c = 0; c < 60; c++) begin
         m_ready = ~m_ready;
         step();
         if (exp_q.size() == 0) break;
      end
      m_ready = 1'b1;
      repeat (3) step();
      check("t6_drained", exp_q.size(), 0);
      check("t6_level_end", level, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule : tb_fifo_stream_out
